// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and stage map for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned DEF_NUM_STAGES = 7;

    // Stage indices of the current MIPS core (0 = youngest, 6 = commit)
    localparam int unsigned STG_PC  = 0;
    localparam int unsigned STG_IF  = 1;
    localparam int unsigned STG_ID  = 2;
    localparam int unsigned STG_EX  = 3;
    localparam int unsigned STG_MEM = 4;
    localparam int unsigned STG_WB  = 5;
    localparam int unsigned STG_CMT = 6;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        PEND  = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_prio.sv
// prio_stall_mask: finds the oldest stalling stage, returns the hold mask for
// it and every younger stage, plus the bubble position just downstream of it.
module prio_stall_mask #(
    parameter int unsigned NUM_STAGES = 7
) (
    input  logic [NUM_STAGES-1:0] req_i,
    output logic [NUM_STAGES-1:0] mask_o,
    output logic [NUM_STAGES-2:0] bubble_o
);

    logic [NUM_STAGES:0] w_above;

    // Prefix-OR from the commit end: stage j holds if it or any older stage stalls
    always_comb begin
        w_above = '0;
        for (int unsigned j = NUM_STAGES; j > 0; j--) begin
            w_above[j-1] = w_above[j] | req_i[j-1];
        end
        mask_o = w_above[NUM_STAGES-1:0];
    end

    // Bubble goes into the register right after the oldest stalling stage
    always_comb begin
        bubble_o = '0;
        for (int unsigned j = 0; j < NUM_STAGES - 1; j++) begin
            bubble_o[j] = req_i[j] & ~w_above[j+1];
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the MIPS pipeline.
// Holds flushes blocked by an older stall, drains a flush over FLUSH_CYCLES,
// and raises a sticky watchdog flag on long stalls.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STAGES    = DEF_NUM_STAGES,
    parameter int unsigned IDX_W         = $clog2(NUM_STAGES),
    parameter int unsigned FLUSH_CYCLES  = 1,
    parameter int unsigned STALL_TIMEOUT = 1024,
    parameter int unsigned CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_STAGES-1:0] stall_req_i,
    input  logic                  flush_req_i,
    input  logic [IDX_W-1:0]      flush_src_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-2:0] flush_o,
    output logic                  flush_busy_o,
    output logic                  stall_timeout_o,
    output logic [CNT_W-1:0]      perf_stall_cnt_o,
    output logic [CNT_W-1:0]      perf_flush_cnt_o
);

    localparam int unsigned DCNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned WD_W   = $clog2(STALL_TIMEOUT + 1);

    localparam logic [IDX_W:0]    LP_NSTG       = (IDX_W+1)'(NUM_STAGES);
    localparam logic [IDX_W-1:0]  LP_LAST       = IDX_W'(NUM_STAGES - 1);
    localparam logic [DCNT_W-1:0] LP_DRAIN_INIT = DCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [DCNT_W-1:0] LP_DRAIN_ONE  = DCNT_W'(1);
    localparam logic [WD_W-1:0]   LP_WD_MAX     = WD_W'(STALL_TIMEOUT);
    localparam logic [WD_W-1:0]   LP_WD_LAST    = WD_W'(STALL_TIMEOUT - 1);
    localparam logic [WD_W-1:0]   LP_WD_ONE     = WD_W'(1);

    ctrl_state_e         r_state;
    ctrl_state_e         w_state_nxt;
    logic [IDX_W-1:0]    r_src;
    logic [IDX_W-1:0]    w_src_nxt;
    logic [DCNT_W-1:0]   r_cnt;
    logic [DCNT_W-1:0]   w_cnt_nxt;
    logic [WD_W-1:0]     r_wd_cnt;
    logic                r_timeout;

    logic [IDX_W-1:0]      w_src_clamp;
    logic [IDX_W-1:0]      w_k;
    logic                  w_new_older;
    logic                  w_have_flush;
    logic                  w_blocked;
    logic                  w_apply;
    logic                  w_restart;
    logic                  w_any_stall;
    logic [NUM_STAGES-1:0] w_le_k;
    logic [NUM_STAGES-2:0] w_lt_k;
    logic [NUM_STAGES-1:0] w_req_eff;
    logic [NUM_STAGES-1:0] w_mask;
    logic [NUM_STAGES-2:0] w_bubble;

    // Effective flush source, blocking test and the stall requests left to honour
    always_comb begin
        w_src_clamp  = ({1'b0, flush_src_i} >= LP_NSTG) ? LP_LAST : flush_src_i;
        w_new_older  = flush_req_i && (w_src_clamp > r_src);
        w_have_flush = flush_req_i || (r_state != RUN);
        if (r_state == RUN || w_new_older) begin
            w_k = w_src_clamp;
        end else begin
            w_k = r_src;
        end
        w_le_k = '0;
        for (int unsigned j = 0; j < NUM_STAGES; j++) begin
            w_le_k[j] = (IDX_W'(j) <= w_k);
        end
        w_lt_k = '0;
        for (int unsigned j = 0; j < NUM_STAGES - 1; j++) begin
            w_lt_k[j] = (IDX_W'(j) < w_k);
        end
        w_blocked = |(stall_req_i & ~w_le_k);
        // Draining re-applies unconditionally; otherwise an older stall blocks
        w_apply   = w_have_flush && ((r_state == DRAIN) || !w_blocked);
        w_req_eff = w_apply ? (stall_req_i & ~w_le_k) : stall_req_i;
    end

    prio_stall_mask #(
        .NUM_STAGES(NUM_STAGES)
    ) u_prio (
        .req_i   (w_req_eff),
        .mask_o  (w_mask),
        .bubble_o(w_bubble)
    );

    // FSM state register with latched source and drain count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_src   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // FSM next state: pend on block, drain after apply, restart on an older source
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_cnt_nxt   = r_cnt;
        w_restart   = 1'b0;
        if (w_have_flush) begin
            w_src_nxt = w_k;
        end
        case (r_state)
            RUN, PEND: begin
                if (w_apply) begin
                    w_restart = 1'b1;
                end else if (w_have_flush) begin
                    w_state_nxt = PEND;
                end
            end
            DRAIN: begin
                if (w_new_older) begin
                    w_restart = 1'b1;
                end else if (r_cnt == LP_DRAIN_ONE) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - LP_DRAIN_ONE;
                end
            end
            default: w_state_nxt = RUN;
        endcase
        if (w_restart) begin
            w_state_nxt = (FLUSH_CYCLES > 1) ? DRAIN : RUN;
            w_cnt_nxt   = LP_DRAIN_INIT;
        end
    end

    // FSM outputs: an applied flush overrides stalls at or below its source
    always_comb begin
        stall_o      = w_apply ? (w_mask & ~w_le_k) : w_mask;
        flush_o      = w_apply ? (w_bubble | w_lt_k) : w_bubble;
        flush_busy_o = (r_state != RUN);
    end

    assign w_any_stall = |stall_o;

    // Watchdog: count consecutive stalled cycles, saturate, sticky flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt  <= '0;
            r_timeout <= 1'b0;
        end else if (w_any_stall) begin
            if (r_wd_cnt != LP_WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + LP_WD_ONE;
            end
            if (r_wd_cnt >= LP_WD_LAST) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wd_cnt <= '0;
        end
    end

    assign stall_timeout_o = r_timeout;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;
    logic             w_first_apply;

    // A drain re-application is not a new flush
    assign w_first_apply = w_apply && (r_state != DRAIN);

    // Free-running wrap-around performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
        end else begin
            if (w_any_stall) begin
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            end
            if (w_first_apply) begin
                r_perf_flush <= r_perf_flush + CNT_W'(1);
            end
        end
    end

    assign perf_stall_cnt_o = r_perf_stall;
    assign perf_flush_cnt_o = r_perf_flush;
`else
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised pipeline stall/flush controller for the MIPS core. Sits beside the datapath and drives hold/bubble controls for NUM_STAGES stages and the NUM_STAGES-1 pipeline registers between them.
- Adds a pending-flush latch for flushes blocked by an older-stage stall.
- Adds a multi-cycle flush drain and a stall watchdog.
- Stage 0 is PC/fetch. Stage NUM_STAGES-1 is commit. Register i sits between stage i and stage i+1.

Parameters:
- NUM_STAGES, 7, number of pipeline stages (min 3).
- IDX_W, $clog2(NUM_STAGES), width of a stage index.
- FLUSH_CYCLES, 1, cycles the flush is held once applied (min 1).
- STALL_TIMEOUT, 1024, consecutive stalled cycles before the watchdog fires.
- CNT_W, 32, perf counter width (used only with the optional feature).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- stall_req_i  in  NUM_STAGES  per-stage stall request.
- flush_req_i  in  1  flush/redirect request.
- flush_src_i  in  IDX_W  stage raising the flush; younger stages (index < src) are squashed.
- stall_o  out  NUM_STAGES  stage i holds its state.
- flush_o  out  NUM_STAGES-1  register i is loaded with a bubble.
- flush_busy_o  out  1  a flush is pending or draining.
- stall_timeout_o  out  1  sticky watchdog flag.
- perf_stall_cnt_o  out  CNT_W  cycles with any stall (optional feature only).
- perf_flush_cnt_o  out  CNT_W  flushes applied (optional feature only).

Behaviour:
- Reset is synchronous, one cycle. All outputs, FSM state, the pending flush and all counters clear to 0, and the FSM enters RUN.
- **Stall resolution (combinational from inputs + state):**
  - s = highest index with stall_req_i set.
  - stall_o[j]=1 for all j<=s.
  - If s<NUM_STAGES-1, flush_o[s]=1 (bubble inserted downstream of the stalled stage).
  - No stall request means stall_o=0.
- **Effective flush source:**
  - k = flush_src_i when flush_req_i is set.
  - Otherwise k = the pending source when in PEND/DRAIN.
- **Flush applies when no stall_req from a stage > k** (older stages stalled block it).
- **When a flush applies:**
  - flush_o[j]=1 for j<k.
  - stall_o[j]=0 for j<=k (redirect overrides a younger stall).
  - Stalls from stages > k are still honoured.
- **FSM:**
  - RUN: flush_req_i and blocked → latch k, go to PEND. flush_req_i and applied → go to DRAIN with cnt=FLUSH_CYCLES-1. If FLUSH_CYCLES=1 and applied, stay in RUN.
  - PEND: re-evaluate the latched k each cycle. When it unblocks, apply the flush and go to DRAIN/RUN as above.
  - DRAIN: re-apply the flush on the latched k every cycle, ignoring stall_req_i from stages <= k. Decrement cnt. At 0, go to RUN.
- **Simultaneous or new flush in PEND/DRAIN:**
  - Keep the larger (older) source index.
  - If the new source is larger, restart cnt.
- flush_busy_o = state != RUN.
- **Watchdog:**
  - Counter increments on any cycle with stall_o nonzero and clears on a cycle with stall_o=0.
  - Reaching STALL_TIMEOUT sets stall_timeout_o. It stays set until rst. The counter saturates.
- flush_src_i >= NUM_STAGES is treated as NUM_STAGES-1.

Optional Feature:
- Macro PIPE_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt_o increments each cycle stall_o is nonzero.
  - perf_flush_cnt_o increments each cycle a new flush is first applied (entry into the applied condition, not each DRAIN cycle).
  - Both wrap at 2^CNT_W and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - typedef ctrl_state_e {RUN, PEND, DRAIN};
  - stage-index constants for the current core (STG_PC=0 … STG_CMT=6);
  - the default NUM_STAGES.
- One natural sub-module: prio_stall_mask (highest-set-bit finder producing the stall mask and bubble position).

Test Plan:
- Stall from stage 4 only: stall_req_i=7'b0010000 → stall_o=7'b0011111, flush_o=6'b010000, same cycle.
- Flush, src 3, no stall, FLUSH_CYCLES=1: flush_o=6'b000111 for exactly one cycle, flush_busy_o stays 0, perf_flush_cnt_o +1.
- Flush src 2 while stage 5 stalled 3 cycles: FSM in PEND, flush_busy_o=1, flush_o[1:0]=0 during the stall. The cycle after the stall drops, flush_o=6'b000011.
- FLUSH_CYCLES=3, flush src 2, then flush src 4 in the 2nd drain cycle: source becomes 4, drain restarts, and flush_o=6'b001111 persists 3 more cycles.
- Stall held at stage 0 for STALL_TIMEOUT cycles: stall_timeout_o rises exactly at cycle STALL_TIMEOUT and stays after the stall clears, until rst.
- rst asserted mid-DRAIN: next cycle all outputs 0, FSM in RUN, counters 0.
